// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: state encoding and default widths.
package product_accumulator_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;
  localparam int ACC_W_DEF  = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a vector of unsigned products from a free-running stream and presents
// the total with a valid/ready handshake. Products arriving while a result is
// waiting are lost and flagged on a sticky error bit.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              drop_err
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   result_q;
  logic               drop_q;

  logic               start_ok;
  logic               launch;
  logic               take;
  logic               last;
  logic               handshake;
  logic [ACC_W-1:0]   sum;

  assign start_ok  = start && (len != '0);
  assign handshake = (state_q == HOLD) && out_ready;
  // A new vector may begin from IDLE or on the cycle the held result drains.
  assign launch    = start_ok && ((state_q == IDLE) || handshake);
  assign take      = (state_q == ACCUM) && in_valid;
  assign last      = take && (count_q == LEN_W'(1));
  assign sum       = acc_q + ACC_W'(product);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ACCUM;
      ACCUM:   if (last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = start_ok ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, accumulator, result and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        acc_q   <= '0;
        count_q <= len;
      end else if (take) begin
        acc_q   <= sum;
        count_q <= count_q - LEN_W'(1);
      end
      if (last) result_q <= sum;
      if ((state_q == HOLD) && in_valid) drop_q <= 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus randomized vectors,
// expected results computed as plain sums of the products sent.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] product;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] result;
  logic        drop_err;

  int passed = 0;
  int total  = 0;
  bit exp_drop = 1'b0;
  logic [31:0] pq[$];
  int          gq[$];

  product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .product(product), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Reference: the result is the plain sum of the vector's products mod 2^40.
  function automatic logic [39:0] model_sum();
    longint unsigned s = 0;
    foreach (pq[i]) s += longint'(pq[i]);
    return s[39:0];
  endfunction

  // Runs one vector of pq with gq idle cycles before each product, holds the
  // result for 'hold' cycles, optionally pushing a product into HOLD.
  task automatic do_vector(input int l, input int hold, input bit drop);
    logic [39:0] exp;
    exp = model_sum();
    start = 1'b1; len = 8'(l); in_valid = 1'b1; product = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < l; i++) begin
      for (int g = 0; g < gq[i]; g++) begin
        in_valid = 1'b0;
        tick();
        chk("gap_state", {62'd0, busy, out_valid}, 64'd2);
      end
      in_valid = 1'b1; product = pq[i];
      // A start during accumulation must be ignored.
      if (i == 0 && l > 1) begin start = 1'b1; len = 8'd1; end
      tick();
      in_valid = 1'b0; start = 1'b0;
      if (i < l - 1) chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("result", {24'd0, result}, {24'd0, exp});
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = (h == 0);  // start without a handshake is ignored
      len = 8'd3;
      if (drop && h == 1) begin in_valid = 1'b1; product = 32'd4; exp_drop = 1'b1; end
      tick();
      in_valid = 1'b0; start = 1'b0;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", {24'd0, result}, {24'd0, exp});
    end
    out_ready = 1'b1;
    tick();
    chk("idle_after", {62'd0, busy, out_valid}, 64'd0);
    chk("result_kept", {24'd0, result}, {24'd0, exp});
    chk("drop_err", {63'd0, drop_err}, {63'd0, exp_drop});
  endtask

  task automatic load(input int n);
    pq.delete(); gq.delete();
    for (int i = 0; i < n; i++) begin
      pq.push_back($urandom);
      gq.push_back(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; product = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_outputs", {busy, out_valid, drop_err, result}, 64'd0);
    rst = 1'b0;

    // Idle products and zero-length start are ignored.
    in_valid = 1'b1; product = 32'd77; tick();
    start = 1'b1; len = 8'd0; tick();
    start = 1'b0; in_valid = 1'b0; tick();
    chk("idle_ignore", {busy, out_valid, drop_err, result}, 64'd0);

    // 5+7+11
    pq = '{32'd5, 32'd7, 32'd11}; gq = '{0, 0, 0};
    do_vector(3, 0, 1'b0);

    // Two max products with a gap
    pq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF}; gq = '{0, 2};
    do_vector(2, 0, 1'b0);
    chk("max_pair", {24'd0, result}, 64'h1_FFFF_FFFE);

    // Held result with a dropped product
    pq = '{32'd9}; gq = '{0};
    do_vector(1, 5, 1'b1);
    chk("held_nine", {24'd0, result}, 64'd9);

    // Back-to-back vectors through the handshake cycle
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    in_valid = 1'b1; product = 32'd8; tick(); in_valid = 1'b0;
    chk("b2b_first", {23'd0, out_valid, result}, {23'd0, 1'b1, 40'd8});
    out_ready = 1'b1; start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    chk("b2b_no_idle", {62'd0, busy, out_valid}, 64'd2);
    in_valid = 1'b1; product = 32'd2; tick();
    product = 32'd3; tick(); in_valid = 1'b0;
    chk("b2b_second", {23'd0, out_valid, result}, {23'd0, 1'b1, 40'd5});
    tick();
    chk("b2b_idle", {62'd0, busy, out_valid}, 64'd0);

    // Reset mid-vector
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    in_valid = 1'b1; product = 32'd100; tick(); tick(); in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; exp_drop = 1'b0;
    chk("rst_mid", {busy, out_valid, drop_err, result}, 64'd0);
    tick();
    chk("rst_no_output", {62'd0, busy, out_valid}, 64'd0);
    pq = '{32'd6}; gq = '{0};
    do_vector(1, 0, 1'b0);

    // Full-length vector of max products
    pq.delete(); gq.delete();
    for (int i = 0; i < 255; i++) begin pq.push_back(32'hFFFF_FFFF); gq.push_back(0); end
    do_vector(255, 0, 1'b0);
    chk("len255", {24'd0, result}, 64'hFE_FFFF_FF01);

    // Randomized vectors
    for (int v = 0; v < 20; v++) begin
      int l;
      l = int'($urandom_range(1, 8));
      load(l);
      do_vector(l, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
